eth_rx_filter: RTL

//  Receive-side filter between the RGMII MAC receive AXIS output and the framing receive buffer writer.

---
 rtl/eth_rx_filter.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_filter.sv
// Receive-side frame filter: forwards the MAC byte stream with one register stage, classifies each
// frame (fcs / runt / giant / address), reports a per-frame status word and keeps statistics counters.
module eth_rx_filter #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_int,
  input  logic             rst_int_n,
  input  logic [47:0]      mac_address,
  input  logic             promiscuous,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic             stat_valid,
  output logic             stat_accept,
  output logic [2:0]       stat_reason,
  output logic [10:0]      stat_len,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_fcs,
  output logic [CNT_W-1:0] cnt_runt,
  output logic [CNT_W-1:0] cnt_giant,
  output logic [CNT_W-1:0] cnt_addr
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HDR  = 2'd2,
    ST_BODY = 2'd3
  } state_e;

  localparam logic [2:0]  RSN_OK    = 3'd0;
  localparam logic [2:0]  RSN_FCS   = 3'd1;
  localparam logic [2:0]  RSN_RUNT  = 3'd2;
  localparam logic [2:0]  RSN_GIANT = 3'd3;
  localparam logic [2:0]  RSN_ADDR  = 3'd4;
  localparam logic [10:0] LEN_SAT   = 11'h7FF;
  localparam logic [10:0] LEN_DEST  = 11'd6;
  localparam logic [10:0] MIN_LEN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);

  // Destination accepted: IPv4 multicast block, broadcast, own station, or promiscuous mode.
  function automatic logic addr_match(input logic [47:0] dest, input logic [47:0] mac,
                                      input logic prom);
    return (dest[47:24] == 24'h01005E) || (dest == {48{1'b1}}) || (dest == mac) || prom;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt, input logic inc,
                                                input logic clr);
    logic [CNT_W-1:0] res;
    if (clr) begin
      res = {CNT_W{1'b0}};
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [47:0]      dest_q, dest_d;
  logic [10:0]      len_q, len_d;
  logic             addr_ok_q, addr_ok_d;
  logic [7:0]       m_tdata_q, m_tdata_d;
  logic             m_tvalid_q, m_tvalid_d;
  logic             m_tlast_q, m_tlast_d;
  logic             m_tuser_q, m_tuser_d;
  logic             stat_valid_q, stat_valid_d;
  logic             stat_accept_q, stat_accept_d;
  logic [2:0]       stat_reason_q, stat_reason_d;
  logic [10:0]      stat_len_q, stat_len_d;
  logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d;
  logic [CNT_W-1:0] cnt_fcs_q, cnt_fcs_d;
  logic [CNT_W-1:0] cnt_runt_q, cnt_runt_d;
  logic [CNT_W-1:0] cnt_giant_q, cnt_giant_d;
  logic [CNT_W-1:0] cnt_addr_q, cnt_addr_d;

  logic             fwd_s;
  logic             eof_s;
  logic [47:0]      dest_shift_s;
  logic [10:0]      len_inc_s;
  logic [10:0]      len_new_s;
  logic             addr_ok_new_s;
  logic [2:0]       reason_s;

  // Frame tracking: state, length, destination capture and address decision.
  always_comb begin
    state_d       = state_q;
    dest_d        = dest_q;
    len_d         = len_q;
    addr_ok_d     = addr_ok_q;
    addr_ok_new_s = addr_ok_q;
    fwd_s         = s_axis_tvalid && (state_q != ST_SYNC);
    eof_s         = fwd_s && s_axis_tlast;
    dest_shift_s  = {dest_q[39:0], s_axis_tdata};
    len_inc_s     = (len_q == LEN_SAT) ? LEN_SAT : (len_q + 11'd1);
    len_new_s     = (state_q == ST_IDLE) ? 11'd1 : len_inc_s;
    case (state_q)
      ST_SYNC: begin
        if (!s_axis_tvalid || s_axis_tlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_IDLE: begin
        if (s_axis_tvalid) begin
          dest_d  = dest_shift_s;
          len_d   = 11'd1;
          state_d = s_axis_tlast ? ST_IDLE : ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (s_axis_tvalid) begin
          dest_d = dest_shift_s;
          len_d  = len_inc_s;
          if (len_inc_s == LEN_DEST) begin
            addr_ok_new_s = addr_match(dest_shift_s, mac_address, promiscuous);
          end else begin
            addr_ok_new_s = addr_ok_q;
          end
          addr_ok_d = addr_ok_new_s;
          if (s_axis_tlast) begin
            state_d = ST_IDLE;
          end else if (len_inc_s == LEN_DEST) begin
            state_d = ST_BODY;
          end else begin
            state_d = ST_HDR;
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_BODY: begin
        if (s_axis_tvalid) begin
          len_d   = len_inc_s;
          state_d = s_axis_tlast ? ST_IDLE : ST_BODY;
        end else begin
          state_d = ST_BODY;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  // End-of-frame classification in priority order: fcs, runt, giant, address.
  always_comb begin
    reason_s = RSN_OK;
    if (s_axis_tuser) begin
      reason_s = RSN_FCS;
    end else if (len_new_s < MIN_LEN_L) begin
      reason_s = RSN_RUNT;
    end else if (len_new_s > MAX_LEN_L) begin
      reason_s = RSN_GIANT;
    end else if (!addr_ok_new_s) begin
      reason_s = RSN_ADDR;
    end else begin
      reason_s = RSN_OK;
    end
  end

  // Output stage, status word and counters; the counters follow the registered status pulse.
  always_comb begin
    m_tdata_d     = s_axis_tdata;
    m_tvalid_d    = fwd_s;
    m_tlast_d     = eof_s;
    m_tuser_d     = eof_s && (reason_s != RSN_OK);
    stat_valid_d  = eof_s;
    stat_accept_d = stat_accept_q;
    stat_reason_d = stat_reason_q;
    stat_len_d    = stat_len_q;
    if (eof_s) begin
      stat_accept_d = (reason_s == RSN_OK);
      stat_reason_d = reason_s;
      stat_len_d    = len_new_s;
    end else begin
      stat_accept_d = stat_accept_q;
    end
    cnt_ok_d    = cnt_next(cnt_ok_q,    stat_valid_q && (stat_reason_q == RSN_OK),    cnt_clr);
    cnt_fcs_d   = cnt_next(cnt_fcs_q,   stat_valid_q && (stat_reason_q == RSN_FCS),   cnt_clr);
    cnt_runt_d  = cnt_next(cnt_runt_q,  stat_valid_q && (stat_reason_q == RSN_RUNT),  cnt_clr);
    cnt_giant_d = cnt_next(cnt_giant_q, stat_valid_q && (stat_reason_q == RSN_GIANT), cnt_clr);
    cnt_addr_d  = cnt_next(cnt_addr_q,  stat_valid_q && (stat_reason_q == RSN_ADDR),  cnt_clr);
  end

  // State and output registers.
  always_ff @(posedge clk_int or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q       <= ST_SYNC;
      dest_q        <= 48'd0;
      len_q         <= 11'd0;
      addr_ok_q     <= 1'b0;
      m_tdata_q     <= 8'd0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
      m_tuser_q     <= 1'b0;
      stat_valid_q  <= 1'b0;
      stat_accept_q <= 1'b0;
      stat_reason_q <= 3'd0;
      stat_len_q    <= 11'd0;
      cnt_ok_q      <= {CNT_W{1'b0}};
      cnt_fcs_q     <= {CNT_W{1'b0}};
      cnt_runt_q    <= {CNT_W{1'b0}};
      cnt_giant_q   <= {CNT_W{1'b0}};
      cnt_addr_q    <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      dest_q        <= dest_d;
      len_q         <= len_d;
      addr_ok_q     <= addr_ok_d;
      m_tdata_q     <= m_tdata_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tlast_q     <= m_tlast_d;
      m_tuser_q     <= m_tuser_d;
      stat_valid_q  <= stat_valid_d;
      stat_accept_q <= stat_accept_d;
      stat_reason_q <= stat_reason_d;
      stat_len_q    <= stat_len_d;
      cnt_ok_q      <= cnt_ok_d;
      cnt_fcs_q     <= cnt_fcs_d;
      cnt_runt_q    <= cnt_runt_d;
      cnt_giant_q   <= cnt_giant_d;
      cnt_addr_q    <= cnt_addr_d;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tuser  = m_tuser_q;
  assign stat_valid    = stat_valid_q;
  assign stat_accept   = stat_accept_q;
  assign stat_reason   = stat_reason_q;
  assign stat_len      = stat_len_q;
  assign cnt_ok        = cnt_ok_q;
  assign cnt_fcs       = cnt_fcs_q;
  assign cnt_runt      = cnt_runt_q;
  assign cnt_giant     = cnt_giant_q;
  assign cnt_addr      = cnt_addr_q;

endmodule
